// File: rtl/parity_frame_pkg.sv
// rtl/parity_frame_pkg.sv - shared types and helpers for the parity-framed serial transmitter
package parity_frame_pkg;

    typedef enum logic [1:0] {
        PFT_IDLE   = 2'd0,
        PFT_DATA   = 2'd1,
        PFT_PARITY = 2'd2
    } pft_state_t;

    localparam bit PFT_LSB_FIRST = 1'b1;

    // Callers zero-extend the word; the extra zeros do not change the XOR.
    function automatic logic calc_parity(input logic [31:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/pft_bit_cnt.sv
// rtl/pft_bit_cnt.sv - loadable modulo-MOD bit counter with terminal-count flag
module pft_bit_cnt #(
    parameter int MOD = 3,
    parameter int CW  = $clog2(MOD)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(MOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// rtl/parity_frame_tx.sv - serialising parity-framed transmitter; PFT_INJECT_ERR_EN adds inj_err parity corruption
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int DATA_W     = 3,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_dat,
    input  logic              in_valid,
`ifdef PFT_INJECT_ERR_EN
    input  logic              inj_err,
`endif
    output logic              in_ready,
    output logic              dat,
    output logic              frame,
    output logic              par_slot,
    output logic              busy
);

    pft_state_t        state, state_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              par_reg, par_next;
    logic              dat_next, frame_next, par_slot_next;
    logic              accept, last_bit, inj;

`ifdef PFT_INJECT_ERR_EN
    assign inj = inj_err;
`else
    assign inj = 1'b0;
`endif

    assign in_ready = (state == PFT_IDLE) || (state == PFT_PARITY);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != PFT_IDLE);

    pft_bit_cnt #(
        .MOD (DATA_W),
        .CW  ($clog2(DATA_W))
    ) u_bit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state == PFT_DATA),
        .tc    (last_bit)
    );

    function automatic logic line_bit(input logic [DATA_W-1:0] s);
        return PFT_LSB_FIRST ? s[0] : s[DATA_W-1];
    endfunction

    // Output flops are loaded with the bit for the coming cycle, so dat is a true register.
    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        par_next      = par_reg;
        dat_next      = 1'b0;
        frame_next    = 1'b0;
        par_slot_next = 1'b0;
        if (state == PFT_DATA) begin
            if (last_bit) begin
                state_next    = PFT_PARITY;
                dat_next      = par_reg;
                par_slot_next = 1'b1;
            end else begin
                shift_next = PFT_LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
                dat_next   = line_bit(shift_next);
            end
        end else if (accept) begin
            state_next = PFT_DATA;
            shift_next = in_dat;
            par_next   = calc_parity(32'(in_dat), ODD_PARITY) ^ inj;
            dat_next   = line_bit(in_dat);
            frame_next = 1'b1;
        end else begin
            state_next = PFT_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PFT_IDLE;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            dat       <= 1'b0;
            frame     <= 1'b0;
            par_slot  <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            par_reg   <= par_next;
            dat       <= dat_next;
            frame     <= frame_next;
            par_slot  <= par_slot_next;
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb/tb_parity_frame_tx.sv - directed table-driven bench for parity_frame_tx (even and odd instances)
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] in_dat = 3'b000;
    logic       in_valid = 1'b0;
`ifdef PFT_INJECT_ERR_EN
    logic       inj_err = 1'b0;
`endif
    logic rdy_e, dat_e, frame_e, par_e, busy_e;
    logic rdy_o, dat_o, frame_o, par_o, busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(3), .ODD_PARITY(1'b0)) dut_even (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_dat   (in_dat),
        .in_valid (in_valid),
`ifdef PFT_INJECT_ERR_EN
        .inj_err  (inj_err),
`endif
        .in_ready (rdy_e),
        .dat      (dat_e),
        .frame    (frame_e),
        .par_slot (par_e),
        .busy     (busy_e)
    );

    parity_frame_tx #(.DATA_W(3), .ODD_PARITY(1'b1)) dut_odd (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_dat   (in_dat),
        .in_valid (in_valid),
`ifdef PFT_INJECT_ERR_EN
        .inj_err  (inj_err),
`endif
        .in_ready (rdy_o),
        .dat      (dat_o),
        .frame    (frame_o),
        .par_slot (par_o),
        .busy     (busy_o)
    );

    typedef struct {
        logic [2:0] word;
        logic [3:0] exp_e;   // dat on cycles 1..4 at bits 0..3, even parity
        logic [3:0] exp_o;   // same, odd parity
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_frame(input logic [2:0] w, input logic [3:0] ee, input logic [3:0] eo);
        @(negedge clk);
        in_dat   = w;
        in_valid = 1'b1;
        chk("ready_idle", {7'd0, rdy_e}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) in_valid = 1'b0;
            chk("dat_even", {7'd0, dat_e}, {7'd0, ee[i]});
            chk("dat_odd", {7'd0, dat_o}, {7'd0, eo[i]});
            chk("frame", {7'd0, frame_e}, {7'd0, i == 0});
            chk("par_slot", {7'd0, par_e}, {7'd0, i == 3});
            chk("busy", {7'd0, busy_e}, 8'd1);
            chk("ready", {7'd0, rdy_e}, {7'd0, i == 3});
        end
        @(negedge clk);
        chk("dat_after", {7'd0, dat_e}, 8'd0);
        chk("busy_after", {7'd0, busy_e}, 8'd0);
    endtask

    logic [7:0] m_dat, m_rdy, m_frm;

    initial begin
        vecs[0] = '{3'b101, 4'b0101, 4'b1101};
        vecs[1] = '{3'b100, 4'b1100, 4'b0100};
        vecs[2] = '{3'b000, 4'b0000, 4'b1000};
        vecs[3] = '{3'b111, 4'b1111, 4'b0111};
        vecs[4] = '{3'b011, 4'b0011, 4'b1011};
        vecs[5] = '{3'b110, 4'b0110, 4'b1110};

        // Reset state
        #1;
        chk("rst_dat", {7'd0, dat_e}, 8'd0);
        chk("rst_frame", {7'd0, frame_e}, 8'd0);
        chk("rst_par", {7'd0, par_e}, 8'd0);
        chk("rst_busy", {7'd0, busy_e}, 8'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {7'd0, rdy_e}, 8'd1);

        foreach (vecs[k]) send_frame(vecs[k].word, vecs[k].exp_e, vecs[k].exp_o);

        // Back-to-back: 111 then 011 with in_valid held high
        m_dat = 8'b0011_1111;
        m_rdy = 8'b1000_1000;
        m_frm = 8'b0001_0001;
        @(negedge clk);
        in_dat   = 3'b111;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("b2b_dat", {7'd0, dat_e}, {7'd0, m_dat[c]});
            chk("b2b_ready", {7'd0, rdy_e}, {7'd0, m_rdy[c]});
            chk("b2b_frame", {7'd0, frame_e}, {7'd0, m_frm[c]});
            chk("b2b_busy", {7'd0, busy_e}, 8'd1);
            if (c == 0) in_dat = 3'b011;
            if (c == 7) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_idle", {7'd0, busy_e}, 8'd0);

        // Hold-off: 010 offered during DATA cycle 2, taken in PARITY
        m_dat = 8'b1010_0101;
        @(negedge clk);
        in_dat   = 3'b101;
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("hold_dat", {7'd0, dat_e}, {7'd0, m_dat[c]});
            chk("hold_ready", {7'd0, rdy_e}, {7'd0, m_rdy[c]});
            chk("hold_frame", {7'd0, frame_e}, {7'd0, m_frm[c]});
            if (c == 0) in_valid = 1'b0;
            if (c == 1) begin
                in_dat   = 3'b010;
                in_valid = 1'b1;
            end
            if (c == 4) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("hold_idle", {7'd0, busy_e}, 8'd0);

        // Reset mid-frame of 110 on cycle 2
        @(negedge clk);
        in_dat   = 3'b110;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_dat_pre", {7'd0, dat_e}, 8'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_dat", {7'd0, dat_e}, 8'd0);
        chk("mid_busy", {7'd0, busy_e}, 8'd0);
        chk("mid_par", {7'd0, par_e}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_dat", {7'd0, dat_e}, 8'd0);
            chk("post_busy", {7'd0, busy_e}, 8'd0);
            chk("post_par", {7'd0, par_e}, 8'd0);
        end

`ifdef PFT_INJECT_ERR_EN
        inj_err = 1'b1;
        send_frame(3'b101, 4'b1101, 4'b0101);
        inj_err = 1'b0;
        send_frame(3'b101, 4'b0101, 4'b1101);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
